// File: rtl/counter_pkg.sv
// Shared types for the counter core: count-boundary behaviour and control FSM states.
package counter_pkg;

   typedef enum logic [1:0] {
      WRAP    = 2'd0,
      SAT     = 2'd1,
      ONESHOT = 2'd2
   } modeT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every DIV enabled cycles; clr restarts the phase at zero.
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] phase;

   assign tick = en && (phase == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= tick ? '0 : phase + CW'(1);
      end
   end

endmodule

// File: rtl/counter_core.sv
// Up/down modulo counter with start/stop control, prescaled stepping and
// selectable boundary behaviour (wrap, saturate, one-shot).
module counter_core
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 2**WIDTH,
   parameter int DIV     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   stateT            state;
   stateT            nextState;
   modeT             modeSel;
   logic [WIDTH-1:0] nextCount;
   logic [WIDTH-1:0] loadClamped;
   logic             nextTc;
   logic             tick;
   logic             tickEn;
   logic             startAccept;
   logic             prescClr;
   logic             atBoundary;

   // Load and stop both pre-empt a tick, so the prescaler must not advance either.
   assign tickEn      = en && (state == RUN) && !load && !stop;
   assign startAccept = start && !stop && (state != RUN);
   assign prescClr    = load || startAccept;
   assign atBoundary  = dir ? (count == MAX_VAL) : (count == '0);
   assign loadClamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

   assign running = (state == RUN);
   assign done    = (state == DONE);

   tick_gen #(
      .DIV(DIV)
   ) uTickGen (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (prescClr),
      .en   (tickEn),
      .tick (tick)
   );

   always_comb begin
      case (mode)
         2'd1:    modeSel = SAT;
         2'd2:    modeSel = ONESHOT;
         default: modeSel = WRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         tc    <= 1'b0;
      end else begin
         state <= nextState;
         count <= nextCount;
         tc    <= nextTc;
      end
   end

   // Load owns the count, stop/start own the state; a tick only arrives when neither pre-empts it.
   always_comb begin
      nextState = state;
      nextCount = count;
      nextTc    = 1'b0;

      if (load) begin
         nextCount = loadClamped;
      end else if (tick) begin
         if (!atBoundary) begin
            nextCount = dir ? count + WIDTH'(1) : count - WIDTH'(1);
         end else begin
            nextTc = 1'b1;
            case (modeSel)
               WRAP:    nextCount = dir ? '0 : MAX_VAL;
               ONESHOT: nextState = DONE;
               default: nextCount = count;
            endcase
         end
      end

      if (stop) begin
         nextState = IDLE;
      end else if (startAccept) begin
         nextState = RUN;
      end
   end

endmodule

// File: doc/counter_core.md
COUNTER_CORE -- requirements
Module: counter_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count register width in bits (>=2).
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 SHALL have parameter DIV, default 1, number of enabled RUN cycles per count step (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  step enable, qualifies prescaler advance.
REQ-007 SHALL have port dir  input  1  1 = count up, 0 = count down.
REQ-008 SHALL have port mode  input  2  WRAP=0, SAT=1, ONESHOT=2; value 3 treated as WRAP.
REQ-009 SHALL have port start  input  1  request RUN.
REQ-010 SHALL have port stop  input  1  request IDLE, count held.
REQ-011 SHALL have port load  input  1  synchronous load of load_val.
REQ-012 SHALL have port load_val  input  WIDTH  load value.
REQ-013 SHALL have port count  output  WIDTH  current count.
REQ-014 SHALL have port running  output  1  high in RUN state.
REQ-015 SHALL have port tc  output  1  one-cycle terminal-count pulse.
REQ-016 SHALL have port done  output  1  high in DONE state.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; count changes only in RUN on a tick, or on load.
REQ-018 SHALL apply per-cycle priority: load > stop > start > tick.
REQ-019 Load SHALL set count to load_val, clamped to MODULUS-1 when load_val >= MODULUS; state unchanged; prescaler cleared.
REQ-020 stop SHALL move RUN or DONE to IDLE next cycle; count held.
REQ-021 start SHALL move IDLE or DONE to RUN next cycle and clear prescaler; start while in RUN SHALL be ignored.
REQ-022 Prescaler SHALL count enabled RUN cycles 0..DIV-1; tick asserted on the cycle it equals DIV-1 with en high, then returns to 0; DIV=1 gives tick every enabled RUN cycle.
REQ-023 en low SHALL freeze prescaler and count.
REQ-024 Boundary: up at MODULUS-1, down at 0.
REQ-025 Tick off boundary SHALL step count by exactly 1 in dir, modulo-free arithmetic within WIDTH bits.
REQ-026 Tick at boundary, WRAP: count to 0 (up) or MODULUS-1 (down); tc pulses next cycle.
REQ-027 Tick at boundary, SAT: count held; tc pulses once per boundary tick.
REQ-028 Tick at boundary, ONESHOT: count held, state to DONE, tc pulses; DONE holds until start or stop.
REQ-029 tc SHALL be registered, high exactly one cycle after the boundary tick, low otherwise.
REQ-030 dir and mode changes SHALL take effect on the next tick without glitching count.
REQ-031 Simultaneous load and boundary tick SHALL take load value, no tc.

Reset
REQ-032 rst_n low SHALL immediately force count=0, state IDLE, prescaler=0, running=0, tc=0, done=0.
REQ-033 Reset asserted mid-RUN SHALL abort with no tc; release returns to IDLE awaiting start.

Structure
REQ-034 Shared package counter_pkg SHALL hold mode enum (WRAP, SAT, ONESHOT) and FSM state enum.
REQ-035 Prescaler SHALL be a sub-module tick_gen (params DIV; ports clk, rst_n, clr, en, tick).
REQ-036 Outputs running/done SHALL decode directly from state register.

Verification
REQ-037 WIDTH=4, MODULUS=10, DIV=1, WRAP, up, start, en=1 -> count 0..9,0; tc high one cycle after 9->0.
REQ-038 WIDTH=4, MODULUS=10, SAT, down from load 2 -> 1,0,0,0; tc pulses each boundary tick at 0.
REQ-039 ONESHOT up, load 7, MODULUS=10 -> 8,9, then DONE, done=1, tc once; start -> RUN, count resumes wrapped behaviour only after next start logic, stays 9 held until load.
REQ-040 DIV=3, en toggled -> one step per 3 cycles of en high; en low freezes mid-prescale.
REQ-041 load_val=15 with MODULUS=10 -> count=9; load and stop same cycle -> count loaded, state IDLE.
REQ-042 rst_n low mid-RUN at count 5 -> count=0, running=0, tc=0 without clock edge.
